// File: rtl/button_grant_arbiter_pkg.sv
// Shared definitions for the button grant arbiter slice.
//   laneState_t : one-shot shaper lane states (sOff/sOn/sWait)
//   arbState_t  : arbiter FSM states (sIdle/sGrant)
//   DROP_MAX    : saturation value of the lost-press counter
//   rrSelect    : round-robin pick of the first set bit after lastId
package button_grant_arbiter_pkg;

  typedef enum logic [1:0] {
    sOff  = 2'd0,
    sOn   = 2'd1,
    sWait = 2'd2
  } laneState_t;

  typedef enum logic {
    sIdle  = 1'b0,
    sGrant = 1'b1
  } arbState_t;

  localparam logic [7:0] DROP_MAX = 8'd255;
  localparam int         MAX_BTN  = 8;

  // Searches lastId+1, lastId+2, ... (mod numBtn) and returns the first set
  // bit. The caller only uses the result when mask is non-zero.
  function automatic logic [2:0] rrSelect(input logic [MAX_BTN-1:0] mask,
                                          input logic [2:0]         lastId,
                                          input int                 numBtn);
    logic [2:0] sel;
    logic [2:0] idx3;
    logic       found;
    int         idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_BTN; k++) begin
      if (k <= numBtn) begin
        idx  = (int'(lastId) + k) % numBtn;
        idx3 = 3'(idx);
        if (!found && mask[idx3]) begin
          sel   = idx3;
          found = 1'b1;
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/button_grant_arbiter_lane.sv
// One-shot shaper for a single button: emits a 1-cycle pulse for each press.
// Ports:
//   Clk         in  system clock
//   Rst         in  asynchronous active-high reset
//   buttonInput in  raw button level, synchronous to Clk
//   pulse       out high for the one cycle after the first high sample
module button_pulse_lane
  import button_grant_arbiter_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic buttonInput,
  output logic pulse
);

  laneState_t stateReg;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stateReg <= sOff;
    end else begin
      case (stateReg)
        sOff:    stateReg <= buttonInput ? sOn : sOff;
        // sOn always lasts a single cycle, so a held button cannot re-fire.
        sOn:     stateReg <= sWait;
        sWait:   stateReg <= buttonInput ? sWait : sOff;
        default: stateReg <= sOff;
      endcase
    end
  end

  // Pure decode of a state register, so still glitch-free and registered.
  assign pulse = (stateReg == sOn);

endmodule

// File: rtl/button_grant_arbiter.sv
// Shares one downstream command consumer among NUM_BTN push-buttons.
// Each button is shaped into single pulses, latched as pending requests and
// granted round-robin over a valid/ack handshake with an ack watchdog.
// Ports:
//   Clk          in  system clock
//   Rst          in  asynchronous active-high reset
//   buttonInput  in  raw button levels [NUM_BTN]
//   grantValid   out a grant is presented to the consumer
//   grantId      out channel granted, stable while grantValid=1 [ID_W]
//   grantAck     in  consumer accepts the grant (ignored while grantValid=0)
//   pendingMask  out registered pending-request bits [NUM_BTN]
//   timeoutPulse out 1-cycle pulse when a grant is abandoned
//   dropCount    out saturating count of presses lost to a pending channel [8]
module button_grant_arbiter
  import button_grant_arbiter_pkg::*;
#(
  parameter int NUM_BTN = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_BTN-1:0] buttonInput,
  output logic               grantValid,
  output logic [ID_W-1:0]    grantId,
  input  logic               grantAck,
  output logic [NUM_BTN-1:0] pendingMask,
  output logic               timeoutPulse,
  output logic [7:0]         dropCount
);

  logic [NUM_BTN-1:0] lanePulse;

  arbState_t          stateReg;
  logic               grantValidReg;
  logic [ID_W-1:0]    grantIdReg;
  logic [ID_W-1:0]    lastIdReg;
  logic [TO_W-1:0]    timerReg;
  logic               timeoutPulseReg;
  logic [NUM_BTN-1:0] pendingReg;
  logic [NUM_BTN-1:0] pendingNext;
  logic [7:0]         dropCountReg;
  logic [7:0]         dropCountNext;

  logic [MAX_BTN-1:0] maskWide;
  logic [2:0]         selWide;
  logic [ID_W-1:0]    selId;
  logic               grantStart;
  logic [NUM_BTN-1:0] clearMask;
  logic [NUM_BTN-1:0] dropVec;
  logic [3:0]         dropInc;
  logic [8:0]         dropSum;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : gLane
      button_pulse_lane uLane (
        .Clk         (Clk),
        .Rst         (Rst),
        .buttonInput (buttonInput[gi]),
        .pulse       (lanePulse[gi])
      );
    end
  endgenerate

  assign maskWide   = MAX_BTN'(pendingReg);
  assign selWide    = rrSelect(maskWide, 3'(lastIdReg), NUM_BTN);
  assign selId      = ID_W'(selWide);
  assign grantStart = (stateReg == sIdle) && (pendingReg != '0);
  assign clearMask  = grantStart ? (NUM_BTN'(1) << selId) : '0;

  // A pulse landing on the bit being cleared re-sets it (set wins) and is
  // not a drop; only a pulse onto a bit that stays pending is lost.
  assign dropVec     = lanePulse & pendingReg & ~clearMask;
  assign pendingNext = (pendingReg & ~clearMask) | lanePulse;

  always_comb begin
    dropInc = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      dropInc = dropInc + 4'(dropVec[k]);
    end
    dropSum = {1'b0, dropCountReg} + 9'(dropInc);
    dropCountNext = (dropSum > 9'(DROP_MAX)) ? DROP_MAX : dropSum[7:0];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pendingReg   <= '0;
      dropCountReg <= '0;
    end else begin
      pendingReg   <= pendingNext;
      dropCountReg <= dropCountNext;
    end
  end

  // Arbiter FSM. Leaving sGrant always passes through sIdle for one cycle,
  // which spaces consecutive grants by at least two cycles.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stateReg        <= sIdle;
      grantValidReg   <= 1'b0;
      grantIdReg      <= '0;
      lastIdReg       <= ID_W'(NUM_BTN - 1);
      timerReg        <= '0;
      timeoutPulseReg <= 1'b0;
    end else begin
      timeoutPulseReg <= 1'b0;
      case (stateReg)
        sIdle: begin
          if (grantStart) begin
            grantIdReg    <= selId;
            grantValidReg <= 1'b1;
            lastIdReg     <= selId;
            timerReg      <= '0;
            stateReg      <= sGrant;
          end
        end
        sGrant: begin
          if (grantAck) begin
            grantValidReg <= 1'b0;
            stateReg      <= sIdle;
          end else if (timerReg == TO_W'(TIMEOUT - 1)) begin
            // Abandoned request is dropped, not re-queued.
            grantValidReg   <= 1'b0;
            timeoutPulseReg <= 1'b1;
            stateReg        <= sIdle;
          end else begin
            timerReg <= timerReg + 1'b1;
          end
        end
        default: begin
          grantValidReg <= 1'b0;
          stateReg      <= sIdle;
        end
      endcase
    end
  end

  assign grantValid   = grantValidReg;
  assign grantId      = grantIdReg;
  assign pendingMask  = pendingReg;
  assign timeoutPulse = timeoutPulseReg;
  assign dropCount    = dropCountReg;

endmodule

// File: tb/tb_button_grant_arbiter.sv
// Directed bench for button_grant_arbiter. dutA uses TIMEOUT=4 for the
// watchdog case; dutB uses the default TIMEOUT for everything else.
module tb_button_grant_arbiter;

  logic       Clk;
  logic       Rst;
  logic [3:0] btnA, btnB;
  logic       ackA, ackB;
  logic       validA, validB;
  logic [1:0] idA, idB;
  logic [3:0] pendA, pendB;
  logic       toA, toB;
  logic [7:0] dropA, dropB;

  int checks;
  int failures;

  button_grant_arbiter #(.NUM_BTN(4), .ID_W(2), .TIMEOUT(4), .TO_W(8)) dutA (
    .Clk(Clk), .Rst(Rst), .buttonInput(btnA), .grantValid(validA),
    .grantId(idA), .grantAck(ackA), .pendingMask(pendA),
    .timeoutPulse(toA), .dropCount(dropA)
  );

  button_grant_arbiter #(.NUM_BTN(4), .ID_W(2), .TIMEOUT(255), .TO_W(8)) dutB (
    .Clk(Clk), .Rst(Rst), .buttonInput(btnB), .grantValid(validB),
    .grantId(idB), .grantAck(ackB), .pendingMask(pendB),
    .timeoutPulse(toB), .dropCount(dropB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] btn;
    logic       ack;
    logic       expValid;
    logic [1:0] expId;
    logic [3:0] expPend;
    logic       expTo;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mkVec(input logic [3:0] btn, input logic ack,
                                 input logic v, input logic [1:0] id,
                                 input logic [3:0] pend, input logic to);
    vec_t r;
    r.btn = btn; r.ack = ack; r.expValid = v; r.expId = id;
    r.expPend = pend; r.expTo = to;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic doReset();
    Rst = 1'b1;
    btnA = '0; btnB = '0; ackA = 1'b0; ackB = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  int  hc;
  int  rises;
  int  firstRise;
  int  pend1Cycles;
  logic prevValid;
  logic [1:0] idAtRise;
  logic [7:0] prevDrop;
  int  wraps;

  initial begin
    checks = 0;
    failures = 0;
    // Round-robin table: ch0..3 pressed together, ack one cycle after valid.
    vecs[0]  = mkVec(4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    vecs[1]  = mkVec(4'b0000, 1'b0, 1'b0, 2'd0, 4'b1111, 1'b0);
    vecs[2]  = mkVec(4'b0000, 1'b0, 1'b1, 2'd0, 4'b1110, 1'b0);
    vecs[3]  = mkVec(4'b0000, 1'b0, 1'b1, 2'd0, 4'b1110, 1'b0);
    vecs[4]  = mkVec(4'b0000, 1'b1, 1'b0, 2'd0, 4'b1110, 1'b0);
    vecs[5]  = mkVec(4'b0000, 1'b0, 1'b1, 2'd1, 4'b1100, 1'b0);
    vecs[6]  = mkVec(4'b0000, 1'b0, 1'b1, 2'd1, 4'b1100, 1'b0);
    vecs[7]  = mkVec(4'b0000, 1'b1, 1'b0, 2'd1, 4'b1100, 1'b0);
    vecs[8]  = mkVec(4'b0000, 1'b0, 1'b1, 2'd2, 4'b1000, 1'b0);
    vecs[9]  = mkVec(4'b0000, 1'b0, 1'b1, 2'd2, 4'b1000, 1'b0);
    vecs[10] = mkVec(4'b0000, 1'b1, 1'b0, 2'd2, 4'b1000, 1'b0);
    vecs[11] = mkVec(4'b0000, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b0);
    vecs[12] = mkVec(4'b0000, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b0);
    vecs[13] = mkVec(4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0);
    vecs[14] = mkVec(4'b0000, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0);

    // Reset state
    doReset();
    check("rst_valid", 32'(validB), 32'd0);
    check("rst_id", 32'(idB), 32'd0);
    check("rst_pend", 32'(pendB), 32'd0);
    check("rst_to", 32'(toB), 32'd0);
    check("rst_drop", 32'(dropB), 32'd0);

    // Table: four simultaneous presses served 0,1,2,3
    for (int i = 0; i < 15; i++) begin
      btnB = vecs[i].btn;
      ackB = vecs[i].ack;
      tick();
      check($sformatf("rr%0d_valid", i), 32'(validB), 32'(vecs[i].expValid));
      check($sformatf("rr%0d_id", i), 32'(idB), 32'(vecs[i].expId));
      check($sformatf("rr%0d_pend", i), 32'(pendB), 32'(vecs[i].expPend));
      check($sformatf("rr%0d_to", i), 32'(toB), 32'(vecs[i].expTo));
    end
    check("rr_drop", 32'(dropB), 32'd0);

    // Ch1 held 20 cycles: one grant, valid 2 cycles after first high sample
    btnB = 4'b0010; ackB = 1'b0;
    rises = 0; firstRise = -1; pend1Cycles = 0; prevValid = 1'b0; idAtRise = 2'd0;
    for (int t = 1; t <= 26; t++) begin
      if (t == 21) btnB = 4'b0000;
      tick();
      if (validB && !prevValid) begin
        rises++;
        if (firstRise < 0) begin
          firstRise = t;
          idAtRise = idB;
        end
      end
      if (pendB[1]) pend1Cycles++;
      prevValid = validB;
      ackB = validB;
    end
    ackB = 1'b0;
    check("hold_grants", 32'(rises), 32'd1);
    check("hold_latency", 32'(firstRise), 32'd3);
    check("hold_id", 32'(idAtRise), 32'd1);
    check("hold_pend_cycles", 32'(pend1Cycles), 32'd1);

    // Watchdog on dutA (TIMEOUT=4): ch2, never acked
    btnA = 4'b0100;
    tick();
    btnA = 4'b0000;
    tick();
    check("to_pend_set", 32'(pendA), 32'b0100);
    tick();
    check("to_valid", 32'(validA), 32'd1);
    check("to_id", 32'(idA), 32'd2);
    hc = 1;
    for (int t = 0; t < 20 && validA; t++) begin
      tick();
      if (validA) hc++;
    end
    check("to_valid_cycles", 32'(hc), 32'd4);
    check("to_pulse", 32'(toA), 32'd1);
    check("to_pend_after", 32'(pendA), 32'd0);
    tick();
    check("to_pulse_end", 32'(toA), 32'd0);
    check("to_valid_end", 32'(validA), 32'd0);

    // Ch0 pressed 3 times while ch1 grant is stalled
    doReset();
    btnB = 4'b0010;
    tick();
    btnB = 4'b0000;
    tick();
    tick();
    check("stall_valid", 32'(validB), 32'd1);
    check("stall_id", 32'(idB), 32'd1);
    for (int p = 0; p < 3; p++) begin
      btnB = 4'b0001;
      tick();
      btnB = 4'b0000;
      tick();
      tick();
    end
    check("stall_pend", 32'(pendB), 32'b0001);
    check("stall_drop", 32'(dropB), 32'd2);
    check("stall_still_valid", 32'(validB), 32'd1);
    ackB = 1'b1;
    tick();
    ackB = 1'b0;
    check("stall_ack_drop", 32'(validB), 32'd0);
    tick();
    check("stall_next_valid", 32'(validB), 32'd1);
    check("stall_next_id", 32'(idB), 32'd0);
    check("stall_next_pend", 32'(pendB), 32'd0);
    ackB = 1'b1;
    tick();
    ackB = 1'b0;

    // Async reset in the middle of a grant on ch2
    doReset();
    btnB = 4'b0100;
    tick();
    btnB = 4'b0000;
    tick();
    tick();
    check("mid_valid", 32'(validB), 32'd1);
    check("mid_id", 32'(idB), 32'd2);
    #2;
    Rst = 1'b1;
    #1;
    check("arst_valid", 32'(validB), 32'd0);
    check("arst_id", 32'(idB), 32'd0);
    check("arst_pend", 32'(pendB), 32'd0);
    check("arst_to", 32'(toB), 32'd0);
    tick();
    Rst = 1'b0;
    btnB = 4'b1000;
    tick();
    btnB = 4'b0000;
    tick();
    tick();
    check("post_rst_valid", 32'(validB), 32'd1);
    check("post_rst_id", 32'(idB), 32'd3);
    ackB = 1'b1;
    tick();
    ackB = 1'b0;

    // Drop counter saturation: repeated ch0 presses against a stalled grant
    doReset();
    prevDrop = 8'd0;
    wraps = 0;
    for (int p = 0; p < 420; p++) begin
      btnB = 4'b0001;
      tick();
      if (dropB < prevDrop) wraps++;
      prevDrop = dropB;
      btnB = 4'b0000;
      tick();
      if (dropB < prevDrop) wraps++;
      prevDrop = dropB;
      tick();
      if (dropB < prevDrop) wraps++;
      prevDrop = dropB;
    end
    check("sat_no_wrap", 32'(wraps), 32'd0);
    check("sat_value", 32'(dropB), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
